// File: rtl/adc_stream_capture.sv
// adc_stream_capture: ADC capture with format conversion, decimation, show-ahead FIFO and status
// Optional ADC_CAPTURE_OR_CLAMP_EN: over-range samples are clamped to full scale of their sign.
module adc_stream_capture #(
  parameter int CHANNELS   = 2,
  parameter int ADC_WIDTH  = 14,
  parameter int OUT_WIDTH  = 16,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [CHANNELS*ADC_WIDTH-1:0]   adc_data,
  input  logic [CHANNELS-1:0]             adc_or,
  input  logic                            cfg_enable,
  input  logic                            cfg_offset_bin,
  input  logic [7:0]                      cfg_decim,
  input  logic                            clr_status,
  output logic [CHANNELS*OUT_WIDTH-1:0]   out_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            status_overflow,
  output logic [15:0]                     status_or_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int DW = CHANNELS*OUT_WIDTH;
  logic [CHANNELS*ADC_WIDTH-1:0] s1_data_q;
  logic [CHANNELS-1:0]           s1_or_q;
  logic [CHANNELS-1:0][ADC_WIDTH-1:0] raw;
  logic [DW-1:0]                 conv_d, s2_data_q, hold_q;
  logic [7:0]                    cnt_q, cnt_d;
  logic [DW-1:0]                 mem [FIFO_DEPTH];
  logic [AW-1:0]                 wr_ptr_q, rd_ptr_q;
  logic [AW:0]                   level_q;
  logic                          ovf_q, keep, full, wr, rd;
  logic [15:0]                   orc_q;
  always_comb begin
    conv_d = '0;
    raw = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      raw[c] = s1_data_q[c*ADC_WIDTH +: ADC_WIDTH] ^ {cfg_offset_bin, {(ADC_WIDTH-1){1'b0}}};
`ifdef ADC_CAPTURE_OR_CLAMP_EN
      if (s1_or_q[c])
        raw[c] = raw[c][ADC_WIDTH-1] ? {1'b1, {(ADC_WIDTH-1){1'b0}}} : {1'b0, {(ADC_WIDTH-1){1'b1}}};
`else
`endif
      conv_d[c*OUT_WIDTH +: OUT_WIDTH] = OUT_WIDTH'($signed(raw[c]));
    end
  end
  // full is taken before any same-cycle pop, so a pop never makes room for the write
  assign keep      = cfg_enable && cnt_q == 8'd0;
  assign cnt_d     = !cfg_enable ? 8'd0 : (cnt_q >= cfg_decim ? 8'd0 : cnt_q + 8'd1);
  assign full      = level_q == (AW+1)'(FIFO_DEPTH);
  assign wr        = keep && !full;
  assign out_valid = level_q != '0;
  assign rd        = out_valid && out_ready;
  assign out_data  = out_valid ? mem[rd_ptr_q] : hold_q;
  assign status_overflow = ovf_q;
  assign status_or_count = orc_q;
  always_ff @(posedge clk)
    if (wr) mem[wr_ptr_q] <= s2_data_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_data_q <= '0;
      s1_or_q   <= '0;
      s2_data_q <= '0;
      cnt_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      hold_q    <= '0;
      ovf_q     <= 1'b0;
      orc_q     <= '0;
    end else begin
      s1_data_q <= adc_data;
      s1_or_q   <= adc_or;
      s2_data_q <= conv_d;
      cnt_q     <= cnt_d;
      if (wr) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (rd) rd_ptr_q <= rd_ptr_q + AW'(1);
      if (rd) hold_q <= mem[rd_ptr_q];
      level_q   <= level_q + (AW+1)'(wr) - (AW+1)'(rd);
      ovf_q     <= clr_status ? 1'b0 : (ovf_q || (keep && full));
      orc_q     <= clr_status ? 16'd0 :
                   (cfg_enable && |s1_or_q && orc_q != 16'hFFFF) ? orc_q + 16'd1 : orc_q;
    end
  end
endmodule

// File: tb/tb_adc_stream_capture.sv
// tb_adc_stream_capture: directed vector table plus multi-cycle sequences for adc_stream_capture
module tb_adc_stream_capture;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [27:0] adc_data;
  logic [1:0]  adc_or;
  logic        cfg_enable, cfg_offset_bin, clr_status, out_ready;
  logic [7:0]  cfg_decim;
  logic [31:0] out_data;
  logic        out_valid, status_overflow;
  logic [15:0] status_or_count;
  int total = 0;
  int bad = 0;
  typedef struct {
    logic        ob;
    logic [13:0] c0, c1;
    logic [15:0] e0, e1;
  } vec_t;
  vec_t tv [6];
  int exp_q [$];
  logic [15:0] clamp_exp;

  adc_stream_capture dut (
    .clk(clk), .reset_n(reset_n), .adc_data(adc_data), .adc_or(adc_or),
    .cfg_enable(cfg_enable), .cfg_offset_bin(cfg_offset_bin), .cfg_decim(cfg_decim),
    .clr_status(clr_status), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .status_overflow(status_overflow), .status_or_count(status_or_count)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [13:0] c0, input logic [13:0] c1);
    adc_data = {c1, c0};
  endtask

  initial begin
    tv[0] = '{1'b0, 14'h0005, 14'h3FFB, 16'h0005, 16'hFFFB};
    tv[1] = '{1'b0, 14'h1FFF, 14'h2000, 16'h1FFF, 16'hE000};
    tv[2] = '{1'b0, 14'h0000, 14'h3FFF, 16'h0000, 16'hFFFF};
    tv[3] = '{1'b1, 14'h2000, 14'h0000, 16'h0000, 16'hE000};
    tv[4] = '{1'b1, 14'h3FFF, 14'h1FFF, 16'h1FFF, 16'hFFFF};
    tv[5] = '{1'b1, 14'h0001, 14'h2001, 16'hE001, 16'h0001};
`ifdef ADC_CAPTURE_OR_CLAMP_EN
    clamp_exp = 16'h1FFF;
`else
    clamp_exp = 16'h1000;
`endif
    reset_n = 1'b0; adc_data = '0; adc_or = '0; cfg_enable = 1'b0; cfg_offset_bin = 1'b0;
    cfg_decim = 8'd0; clr_status = 1'b0; out_ready = 1'b0;
    #12;
    chk("reset_valid", 32'(out_valid), 32'd0);
    chk("reset_data", out_data, 32'd0);
    chk("reset_ovf", 32'(status_overflow), 32'd0);
    chk("reset_orc", 32'(status_or_count), 32'd0);
    @(negedge clk) reset_n = 1'b1;
    // first sample on enable
    drive(14'h0005, 14'h3FFB);
    repeat (3) @(negedge clk);
    chk("idle_valid", 32'(out_valid), 32'd0);
    cfg_enable = 1'b1;
    @(negedge clk);
    chk("first_valid", 32'(out_valid), 32'd1);
    chk("first_data", out_data, 32'hFFFB_0005);
    out_ready = 1'b1;
    // conversion table
    for (int i = 0; i < 6; i++) begin
      cfg_offset_bin = tv[i].ob;
      drive(tv[i].c0, tv[i].c1);
      repeat (2) @(negedge clk);
      if (i > 0 && tv[i].ob == tv[i-1].ob)
        chk("latency_old", out_data, {tv[i-1].e1, tv[i-1].e0});
      @(negedge clk);
      chk("vec_valid", 32'(out_valid), 32'd1);
      chk("vec_ch0", 32'(out_data[15:0]), 32'(tv[i].e0));
      chk("vec_ch1", 32'(out_data[31:16]), 32'(tv[i].e1));
    end
    cfg_enable = 1'b0;
    @(negedge clk);
    chk("drained", 32'(out_valid), 32'd0);
    // decimation by 4, then switch to 1 at a wrap
    out_ready = 1'b0; cfg_offset_bin = 1'b0; cfg_decim = 8'd3;
    for (int v = 0; v < 24; v++) begin
      @(negedge clk);
      drive(14'(v), 14'h0);
      if (v == 2) cfg_enable = 1'b1;
      if (v == 17) cfg_decim = 8'd0;
    end
    @(negedge clk);
    cfg_enable = 1'b0; out_ready = 1'b1;
    exp_q = '{0, 4, 8, 12, 16, 17, 18, 19, 20, 21};
    foreach (exp_q[i]) begin
      chk("decim_valid", 32'(out_valid), 32'd1);
      chk("decim_data", out_data, 32'(exp_q[i]));
      @(negedge clk);
    end
    chk("decim_empty", 32'(out_valid), 32'd0);
    // fill to full and overflow
    out_ready = 1'b0;
    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      if (i == 18) begin
        chk("full_no_ovf", 32'(status_overflow), 32'd0);
        chk("full_head", out_data, 32'd1);
      end
      if (i == 19) chk("ovf_set", 32'(status_overflow), 32'd1);
      drive(14'(i + 1), 14'h0);
      if (i == 2) cfg_enable = 1'b1;
    end
    @(negedge clk);
    cfg_enable = 1'b0; clr_status = 1'b1;
    @(negedge clk);
    clr_status = 1'b0;
    chk("ovf_clr", 32'(status_overflow), 32'd0);
    // pop in the same cycle as a write into a full FIFO still drops the write
    cfg_enable = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    cfg_enable = 1'b0; out_ready = 1'b0;
    chk("ovf_rw", 32'(status_overflow), 32'd1);
    out_ready = 1'b1;
    for (int v = 2; v <= 16; v++) begin
      chk("full_drain", out_data, 32'(v));
      @(negedge clk);
    end
    chk("full_empty", 32'(out_valid), 32'd0);
    chk("hold_last", out_data, 32'd16);
    clr_status = 1'b1;
    @(negedge clk);
    clr_status = 1'b0;
    chk("ovf_clr2", 32'(status_overflow), 32'd0);
    // over-range counting
    cfg_enable = 1'b1; drive(14'h1000, 14'h0); adc_or = 2'b01;
    repeat (4) @(negedge clk);
    @(negedge clk);
    adc_or = 2'b00;
    chk("clamp_ch0", out_data, {16'h0000, clamp_exp});
    repeat (2) @(negedge clk);
    chk("orc_5", 32'(status_or_count), 32'd5);
    cfg_enable = 1'b0; adc_or = 2'b01;
    repeat (3) @(negedge clk);
    adc_or = 2'b00;
    repeat (2) @(negedge clk);
    chk("orc_disabled", 32'(status_or_count), 32'd5);
    cfg_enable = 1'b1; adc_or = 2'b01;
    repeat (2) @(negedge clk);
    chk("orc_6", 32'(status_or_count), 32'd6);
    clr_status = 1'b1; adc_or = 2'b00;
    @(negedge clk);
    clr_status = 1'b0;
    chk("orc_clr_wins", 32'(status_or_count), 32'd0);
    @(negedge clk);
    chk("orc_after_clr", 32'(status_or_count), 32'd0);
    cfg_enable = 1'b0;
    repeat (2) @(negedge clk);
    // async reset mid-burst
    out_ready = 1'b0; drive(14'h0123, 14'h0456); cfg_enable = 1'b1;
    repeat (8) @(negedge clk);
    chk("burst_valid", 32'(out_valid), 32'd1);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("async_valid", 32'(out_valid), 32'd0);
    chk("async_data", out_data, 32'd0);
    @(negedge clk);
    cfg_enable = 1'b0; out_ready = 1'b1; reset_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("post_rst_valid", 32'(out_valid), 32'd0);
    chk("post_rst_data", out_data, 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
